// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO and the blocks that sit around it.
// Holds the default widths and the occupancy sizing used by the drain buffer.
package sync_fifo_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int BUF_DEPTH_DEF  = 3;

  // Occupancy must represent 0..depth inclusive, hence depth + 1 codes.
  typedef logic [$clog2(BUF_DEPTH_DEF + 1)-1:0] occ_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_drain_buf.sv
// Small circular register buffer with push/pop and an occupancy count.
// The head entry is presented directly so the consumer sees a registered word.
module fifo_drain_buf
  import sync_fifo_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  DEPTH  = BUF_DEPTH_DEF,
  localparam int OCC_W  = occ_width(DEPTH),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [OCC_W-1:0]  occ
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      // NOTE: the storage is reset as well, because the head entry is the
      // visible output word and must read as zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= wrap_inc(tail);
      end
      if (pop) head <= wrap_inc(head);
      occ <= occ + OCC_W'(push) - OCC_W'(pop);
    end
  end

  assign head_data = mem[head];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || clr)
    !(push && !pop && (occ == OCC_W'(DEPTH))));

  a_no_underflow: assert property (@(posedge clk) disable iff (rst || clr)
    !(pop && (occ == '0)));

endmodule

// File: rtl/fifo_stream_drain.sv
// Drains the synchronous FIFO's read port onto a valid/ready stream at one word
// per clock, hiding the FIFO's one-cycle read latency with a small output buffer.
module fifo_stream_drain
  import sync_fifo_pkg::*;
#(
  parameter int  DATA_W    = DATA_W_DEF,
  parameter int  BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int  CNT_W     = 16,
  localparam int OCC_W     = occ_width(BUF_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  xfer_count,
  output logic              busy
);

  logic             pend;
  logic             capture;
  logic             pop;
  logic [OCC_W-1:0] occ;

  // The issue decision reserves a slot for the word already in flight, so it
  // only looks at registered state and never at m_ready.
  assign fifo_rd_en = !rst && !flush && !fifo_empty &&
                      ((int'(occ) + int'(pend)) < BUF_DEPTH);

  assign m_valid = (occ != '0) && !flush;
  assign pop     = m_valid && m_ready;
  assign capture = pend && !flush;
  assign busy    = (occ != '0) || pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= 1'b0;
      xfer_count <= '0;
    end else begin
      pend <= fifo_rd_en;
      if (pop) xfer_count <= xfer_count + CNT_W'(1);
    end
  end

  fifo_drain_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (capture),
    .push_data (fifo_data),
    .pop       (pop),
    .head_data (m_data),
    .occ       (occ)
  );

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: a behavioural FIFO feeds the block, and a
// negedge monitor scores every output handshake against the pushed word order.
module tb_fifo_stream_drain;

  localparam int DATA_W    = 32;
  localparam int BUF_DEPTH = 3;
  localparam int CNT_W     = 4;
  localparam int MEM_N     = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd_en;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              flush;
  logic [CNT_W-1:0]  xfer_count;
  logic              busy;

  int total = 0;
  int bad   = 0;

  // Behavioural FIFO: words written by the stimulus, read one per rd_en,
  // data returned one cycle after the accepted read.
  logic [DATA_W-1:0] fifo_mem [MEM_N];
  int                wr_cnt = 0;
  int                rd_cnt = 0;

  // Scoreboard: every pushed word, in order; consumed = output or flushed.
  logic [DATA_W-1:0] exp_q [$];
  int                consumed = 0;
  int                exp_cnt  = 0;
  logic              stall_q  = 1'b0;
  logic [DATA_W-1:0] held     = '0;

  always #5 clk = ~clk;

  assign fifo_empty = (wr_cnt == rd_cnt);

  fifo_stream_drain #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .flush      (flush),
    .xfer_count (xfer_count),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      rd_cnt    <= 0;
      fifo_data <= '0;
    end else if (fifo_rd_en) begin
      fifo_data <= fifo_mem[rd_cnt % MEM_N];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      consumed = 0;
      exp_cnt  = 0;
      stall_q  = 1'b0;
    end else begin
      check("xfer_count", xfer_count, exp_cnt[CNT_W-1:0]);
      check("rd_en_while_empty", fifo_rd_en && fifo_empty, 0);
      if (flush) begin
        check("flush_outputs", {m_valid, fifo_rd_en}, 0);
        // Everything already read from the FIFO but not yet output is lost.
        while (consumed < rd_cnt && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          consumed++;
        end
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          check("hold_valid", m_valid, 1);
          check("hold_data", m_data, held);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) check("spurious_word", 1, 0);
          else check("m_data", m_data, exp_q.pop_front());
          consumed++;
          exp_cnt++;
        end
        stall_q = m_valid && !m_ready;
        held    = m_data;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    fifo_mem[wr_cnt % MEM_N] = w;
    exp_q.push_back(w);
    wr_cnt++;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b0;
    wr_cnt  = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_consumed(input int n, input int budget, input string name);
    int c = 0;
    while (consumed < n && c < budget) begin
      step();
      c++;
    end
    check(name, consumed >= n, 1);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int c = 0;
    @(negedge clk);
    while (!m_valid && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, m_valid, 1);
  endtask

  initial begin
    int base;
    int r0;
    int cnt0;

    rst     = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b0;
    do_reset();

    // Reset state and idle with an empty FIFO.
    @(negedge clk);
    check("reset_m_data", m_data, 0);
    repeat (20) begin
      @(negedge clk);
      check("idle_outputs", {fifo_rd_en, m_valid, busy, xfer_count}, 0);
    end

    // Single word: issue, capture edge, then valid.
    step();
    m_ready = 1'b1;
    push(32'hA5A5_0001);
    @(negedge clk);
    check("single_issue", fifo_rd_en, 1);
    check("single_not_yet_valid", m_valid, 0);
    step();
    @(negedge clk);
    check("single_issue_once", fifo_rd_en, 0);
    check("single_in_flight_valid", m_valid, 0);
    check("single_busy", busy, 1);
    step();
    @(negedge clk);
    check("single_valid", m_valid, 1);
    check("single_data", m_data, 32'hA5A5_0001);
    step();
    @(negedge clk);
    check("single_count", xfer_count, 1);
    check("single_idle", {m_valid, busy}, 0);

    // Full-rate burst of 8 words.
    step();
    for (int i = 0; i < 8; i++) push(i);
    wait_valid(10, "burst_start");
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check("burst_rate", m_valid, 1);
    end
    @(negedge clk);
    check("burst_count", xfer_count, 9);
    check("burst_done", m_valid, 0);

    // Backpressure: buffer saturates, issue stops, head word holds.
    step();
    m_ready = 1'b0;
    base    = consumed;
    r0      = rd_cnt;
    for (int i = 0; i < 8; i++) push(100 + i);
    repeat (10) step();
    @(negedge clk);
    check("bp_reads", rd_cnt - r0, BUF_DEPTH);
    check("bp_rd_en", fifo_rd_en, 0);
    check("bp_valid", m_valid, 1);
    check("bp_head", m_data, 100);
    step();
    m_ready = 1'b1;
    wait_consumed(base + 8, 40, "bp_drain");

    // Flush with occ = 2 and a read in flight.
    step();
    m_ready = 1'b0;
    base    = consumed;
    for (int i = 0; i < 5; i++) push(200 + i);
    step();
    step();
    step();
    cnt0  = exp_cnt;
    flush = 1'b1;
    @(negedge clk);
    check("flush_busy_before", busy, 1);
    check("flush_m_valid", m_valid, 0);
    step();
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy_after", busy, 0);
    check("flush_valid_after", m_valid, 0);
    check("flush_count_kept", xfer_count, cnt0[CNT_W-1:0]);
    step();
    m_ready = 1'b1;
    wait_valid(10, "flush_resume");
    check("flush_next_word", m_data, 203);
    step();
    wait_consumed(base + 5, 40, "flush_drain");

    // Randomised traffic with random backpressure and occasional flush.
    for (int c = 0; c < 400; c++) begin
      step();
      if ($urandom_range(99) < 35) push($urandom);
      m_ready = ($urandom_range(99) < 60);
      flush   = ($urandom_range(99) < 3);
    end
    step();
    flush   = 1'b0;
    m_ready = 1'b1;
    wait_consumed(wr_cnt, 300, "random_drain");
    step();
    @(negedge clk);
    check("random_queue_empty", exp_q.size(), 0);
    check("random_idle", busy, 0);

    // Counter wrap: 17 transfers through a 4-bit counter.
    step();
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push(32'h1000 + i);
    wait_consumed(17, 100, "wrap_drain");
    @(negedge clk);
    check("wrap_count", xfer_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
